nco_tuner: RTL

Frequency-tuning stage directly upstream of the NCO. Accepts a target phase-increment command over a valid/ready handshake and drives the NCO `phase_increment` input. The output either jumps to the target or ramps toward it in fixed steps at a programmable dwell rate, giving glitch-free retuning and linear chirps. The `phase_increment` output connects straight to the NCO's `phase_increment` input.

---
 rtl/sdr_pkg.sv | 11 +
 rtl/nco_tuner_dwell_timer.sv | 29 ++
 rtl/nco_tuner.sv | 111 +++++++++++
 3 files changed

// File: rtl/sdr_pkg.sv
// Types and constants shared by the SDR front-end blocks (NCO, tuner).
package sdr_pkg;

    localparam int unsigned DEFAULT_REGISTER_WIDTH = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } nco_tuner_state_t;

endpackage

// File: rtl/nco_tuner_dwell_timer.sv
// Dwell counter: ticks once every (limit + 1) enabled cycles, then restarts from zero.
module dwell_timer
    import sdr_pkg::*;
#(
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [DWELL_WIDTH-1:0] limit,
    output logic                   tick
);

    logic [DWELL_WIDTH-1:0] cnt;

    assign tick = enable && (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nco_tuner.sv
// NCO tuning stage: jumps or ramps phase_increment toward a commanded target
// in fixed steps, with a programmable dwell between steps.
module nco_tuner
    import sdr_pkg::*;
#(
    parameter int unsigned                REGISTER_WIDTH  = DEFAULT_REGISTER_WIDTH,
    parameter int unsigned                DWELL_WIDTH     = 16,
    parameter logic [REGISTER_WIDTH-1:0]  RESET_INCREMENT = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [REGISTER_WIDTH-1:0] target_increment,
    input  logic [REGISTER_WIDTH-1:0] step_size,
    input  logic [DWELL_WIDTH-1:0]    dwell_cycles,
    output logic [REGISTER_WIDTH-1:0] phase_increment,
    output logic                      ramp_active,
    output logic                      locked
);

    nco_tuner_state_t          state, state_n;
    logic [REGISTER_WIDTH-1:0] target_reg, target_n;
    logic [REGISTER_WIDTH-1:0] step_reg, step_n;
    logic [DWELL_WIDTH-1:0]    dwell_reg, dwell_n;
    logic                      dir_up, dir_up_n;
    logic [REGISTER_WIDTH-1:0] inc_n;
    logic [REGISTER_WIDTH-1:0] diff;
    logic                      timer_clear;
    logic                      timer_tick;
    logic                      accept;

    dwell_timer #(
        .DWELL_WIDTH(DWELL_WIDTH)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (state == RAMP),
        .limit  (dwell_reg),
        .tick   (timer_tick)
    );

    assign accept = cmd_valid && (state == IDLE);
    // Distance is taken fresh from both registers so the clamp cannot overshoot or wrap.
    assign diff   = (target_reg > phase_increment) ? (target_reg - phase_increment)
                                                   : (phase_increment - target_reg);

    always_comb begin
        state_n     = state;
        target_n    = target_reg;
        step_n      = step_reg;
        dwell_n     = dwell_reg;
        dir_up_n    = dir_up;
        inc_n       = phase_increment;
        timer_clear = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    target_n = target_increment;
                    step_n   = step_size;
                    dwell_n  = dwell_cycles;
                    if ((step_size == '0) || (target_increment == phase_increment)) begin
                        inc_n = target_increment;
                    end else begin
                        dir_up_n    = target_increment > phase_increment;
                        timer_clear = 1'b1;
                        state_n     = RAMP;
                    end
                end
            end
            RAMP: begin
                if (timer_tick) begin
                    if (diff <= step_reg) begin
                        inc_n   = target_reg;
                        state_n = IDLE;
                    end else if (dir_up) begin
                        inc_n = phase_increment + step_reg;
                    end else begin
                        inc_n = phase_increment - step_reg;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            phase_increment <= RESET_INCREMENT;
            target_reg      <= RESET_INCREMENT;
            step_reg        <= '0;
            dwell_reg       <= '0;
            dir_up          <= 1'b0;
        end else begin
            state           <= state_n;
            phase_increment <= inc_n;
            target_reg      <= target_n;
            step_reg        <= step_n;
            dwell_reg       <= dwell_n;
            dir_up          <= dir_up_n;
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign ramp_active = (state == RAMP);
    assign locked      = (phase_increment == target_reg);

endmodule
